// File: rtl/model_trainer_integration_vector.sv
// model_trainer_integration_vector
//   Time-domain integrator: inverse of the trainer differentiation stage.
//   Vectors stream in one element per DATA_IN_ENABLE. For each element index i
//   the block emits y_t[i] = y_(t-1)[i] + LENGTH_IN * x_t[i], with y_(-1)[i] = 0.
//   Per-index running sums live in an internal buffer of MAX_SIZE entries.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   START             begins a run; only sampled in IDLE
//   READY             one-cycle pulse at the end of a run
//   DATA_IN_ENABLE    DATA_IN valid this cycle
//   DATA_IN           x_t[i], signed
//   SIZE_IN           vector length, clamped to MAX_SIZE, latched at START
//   TIME_IN           number of time steps, latched at START
//   LENGTH_IN         integration step, signed, latched at START
//   DATA_OUT_ENABLE   DATA_OUT valid this cycle (1 cycle after the input)
//   DATA_ENABLE       marks the last element of each step
//   DATA_OUT          y_t[i]; holds its value while DATA_OUT_ENABLE = 0
module model_trainer_integration_vector #(
  parameter int DATA_SIZE = 64,
  parameter int MAX_SIZE  = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  input  logic [DATA_SIZE-1:0] SIZE_IN,
  input  logic [DATA_SIZE-1:0] TIME_IN,
  input  logic [DATA_SIZE-1:0] LENGTH_IN,
  output logic                 DATA_OUT_ENABLE,
  output logic                 DATA_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int IW = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;  // index width
  localparam int SW = $clog2(MAX_SIZE + 1);                   // size width (0..MAX_SIZE)

  typedef enum logic [1:0] {IDLE, INPUT, ENDER} state_t;

  state_t               state, state_nxt;
  logic [SW-1:0]        size_r, size_c;
  logic [DATA_SIZE-1:0] time_r, len_r, t_r;
  logic [IW-1:0]        i_r;
  logic [DATA_SIZE-1:0] buf_mem [MAX_SIZE];

  logic                 accept, last_i, last_t;
  logic [DATA_SIZE-1:0] p, y;

  // Clamp the requested length so the index never leaves the buffer.
  assign size_c = (SIZE_IN > DATA_SIZE'(MAX_SIZE)) ? SW'(MAX_SIZE) : SW'(SIZE_IN);

  assign accept = (state == INPUT) && DATA_IN_ENABLE;
  assign last_i = (SW'(i_r) == size_r - SW'(1));
  assign last_t = (t_r == time_r - DATA_SIZE'(1));

  // The low DATA_SIZE bits of a two's complement product do not depend on
  // operand signedness, so a same-width multiply equals the truncated
  // signed full product.
  assign p = DATA_IN * len_r;

  // Step 0 never reads the buffer, so leftovers from earlier runs are harmless.
  assign y = ((t_r == '0) ? '0 : buf_mem[i_r]) + p;

  assign READY = (state == ENDER);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START)
                 state_nxt = (size_c == '0 || TIME_IN == '0) ? ENDER : INPUT;
      INPUT:   if (accept && last_i && last_t) state_nxt = ENDER;
      ENDER:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      size_r          <= '0;
      time_r          <= '0;
      len_r           <= '0;
      i_r             <= '0;
      t_r             <= '0;
      DATA_OUT        <= '0;
      DATA_OUT_ENABLE <= 1'b0;
      DATA_ENABLE     <= 1'b0;
    end else begin
      DATA_OUT_ENABLE <= accept;
      DATA_ENABLE     <= accept && last_i;
      if (state == IDLE && START) begin
        size_r <= size_c;
        time_r <= TIME_IN;
        len_r  <= LENGTH_IN;
        i_r    <= '0;
        t_r    <= '0;
      end
      if (accept) begin
        DATA_OUT <= y;
        if (last_i) begin
          i_r <= '0;
          t_r <= t_r + DATA_SIZE'(1);
        end else begin
          i_r <= i_r + IW'(1);
        end
      end
    end
  end

  // Accumulator storage: no reset so it can map onto RAM.
  always_ff @(posedge CLK) begin
    if (accept) buf_mem[i_r] <= y;
  end

endmodule

// File: tb/tb_model_trainer_integration_vector.sv
module tb_model_trainer_integration_vector;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        DATA_IN_ENABLE = 1'b0;
  logic [63:0] DATA_IN = '0, SIZE_IN = '0, TIME_IN = '0, LENGTH_IN = '0;
  logic        READY, DATA_OUT_ENABLE, DATA_ENABLE;
  logic [63:0] DATA_OUT;

  typedef struct {
    logic [63:0] d;
    logic        oe;
    logic        de;
    logic        rdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] din_q[$];
  logic [63:0] acc[64];
  logic [63:0] last_out = '0;
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  model_trainer_integration_vector #(.DATA_SIZE(64), .MAX_SIZE(64)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_IN(DATA_IN),
    .SIZE_IN(SIZE_IN), .TIME_IN(TIME_IN), .LENGTH_IN(LENGTH_IN),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_ENABLE(DATA_ENABLE),
    .DATA_OUT(DATA_OUT)
  );

  // Monitor: any output activity pops one expectation; quiet cycles must hold DATA_OUT.
  always @(negedge CLK) begin
    if (RST) begin
      last_out = '0;
    end else if (DATA_OUT_ENABLE || DATA_ENABLE || READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output oe=%0b de=%0b rdy=%0b data=%h, required no output",
                 DATA_OUT_ENABLE, DATA_ENABLE, READY, DATA_OUT);
      end else begin
        mon_e = exp_q.pop_front();
        if (DATA_OUT_ENABLE !== mon_e.oe || DATA_ENABLE !== mon_e.de || READY !== mon_e.rdy ||
            (mon_e.oe && DATA_OUT !== mon_e.d)) begin
          errors++;
          $display("FAIL output got oe=%0b de=%0b rdy=%0b data=%h, required oe=%0b de=%0b rdy=%0b data=%h",
                   DATA_OUT_ENABLE, DATA_ENABLE, READY, DATA_OUT,
                   mon_e.oe, mon_e.de, mon_e.rdy, mon_e.d);
        end
      end
      if (DATA_OUT_ENABLE) last_out = DATA_OUT;
    end else begin
      checks++;
      if (DATA_OUT !== last_out) begin
        errors++;
        $display("FAIL hold data=%h, required %h", DATA_OUT, last_out);
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic send(input logic [63:0] x, input int gap);
    repeat (gap) @(negedge CLK);
    DATA_IN_ENABLE = 1'b1;
    DATA_IN        = x;
    @(negedge CLK);
    DATA_IN_ENABLE = 1'b0;
    DATA_IN        = {$urandom, $urandom};
  endtask

  task automatic push(input logic [63:0] d, input logic oe, input logic de, input logic rdy);
    exp_t e;
    e.d = d; e.oe = oe; e.de = de; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  // One complete run. Reference: y[t][i] = y[t-1][i] + len*x (mod 2^64), y[-1] = 0.
  // Data comes from din_q when present, otherwise random.
  task automatic run(input int sz, input int tm, input logic [63:0] len,
                     input int gap, input bit disturb);
    int          eff;
    logic [63:0] x;
    bit          first;
    eff   = (sz > 64) ? 64 : sz;
    first = 1'b1;
    SIZE_IN = 64'(sz); TIME_IN = 64'(tm); LENGTH_IN = len;
    START = 1'b1;
    if (eff == 0 || tm == 0) push('0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    START = 1'b0;
    for (int t = 0; t < tm && eff > 0; t++) begin
      for (int i = 0; i < eff; i++) begin
        x = (din_q.size() != 0) ? din_q.pop_front() : {$urandom, $urandom};
        acc[i] = ((t == 0) ? 64'd0 : acc[i]) + x * len;
        push(acc[i], 1'b1, i == eff - 1, (i == eff - 1) && (t == tm - 1));
        send(x, $urandom_range(gap, 0));
        if (disturb && first) begin
          // Mid-run START and operand changes must be ignored.
          START = 1'b1; SIZE_IN = 64'd1; TIME_IN = 64'd1; LENGTH_IN = {$urandom, $urandom};
          @(negedge CLK);
          START = 1'b0;
        end
        first = 1'b0;
      end
    end
    // Strobes while in ENDER and IDLE must produce nothing.
    for (int k = 0; k < 3; k++) send({$urandom, $urandom}, 0);
    drain();
  endtask

  task automatic chk_reset_outputs(input string tag);
    checks++;
    if (DATA_OUT !== '0 || DATA_OUT_ENABLE !== 1'b0 || DATA_ENABLE !== 1'b0 || READY !== 1'b0) begin
      errors++;
      $display("FAIL %s data=%h oe=%0b de=%0b rdy=%0b, required all 0",
               tag, DATA_OUT, DATA_OUT_ENABLE, DATA_ENABLE, READY);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout, required run to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 RST = 1'b1;
    #1 chk_reset_outputs("reset_state");
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);

    // 1: basic two-step run
    din_q = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6};
    run(3, 2, 64'd1, 0, 1'b0);

    // 2: signed step scaling
    din_q = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4};
    run(1, 3, 64'd3, 0, 1'b0);

    // 3: wrap-around
    din_q = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
    run(1, 2, 64'd1, 0, 1'b0);

    // 4: empty runs
    run(0, 5, 64'd1, 0, 1'b0);
    run(3, 0, 64'd1, 0, 1'b0);

    // 5: reset mid-run, then a fresh run
    SIZE_IN = 64'd2; TIME_IN = 64'd2; LENGTH_IN = 64'd1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    push(64'd7, 1'b1, 1'b0, 1'b0); send(64'd7, 0);
    push(64'd8, 1'b1, 1'b1, 1'b0); send(64'd8, 0);
    drain();
    #2 RST = 1'b1;
    #1 chk_reset_outputs("reset_mid_run");
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    din_q = '{64'd10, 64'd20};
    run(2, 1, 64'd1, 0, 1'b0);

    // 6: test 1 again with idle gaps and a mid-run START
    din_q = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6};
    run(3, 2, 64'd1, 3, 1'b1);

    // Size clamp to buffer depth
    run(100, 2, {$urandom, $urandom}, 0, 1'b0);

    // Randomized runs
    for (int r = 0; r < 10; r++)
      run($urandom_range(6, 1), $urandom_range(4, 1), {$urandom, $urandom}, 3, 1'($urandom_range(1, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
